// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch front end.
package rv_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DRAIN,
    FAULT
  } fetch_state_e;

  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/rv_fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues one imem read at a time and
// presents each fetched word to decode; handles redirects and misaligned targets.
//
// state | meaning
// IDLE  | first cycle after reset release, no request yet
// REQ   | imem_req_valid high at pc, waiting for imem_req_ready
// WAIT  | one request accepted, waiting for its response
// HOLD  | instruction presented to decode, waiting for instr_ready
// DRAIN | squashed request outstanding, its response will be dropped
// FAULT | misaligned redirect seen, fetch stopped until an aligned redirect
module rv_fetch_sequencer
  import rv_fetch_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr_data,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  output logic            misaligned_fault,
  output logic [XLEN-1:0] fault_pc
);

  if (XLEN != 32) begin : g_xlen_check
    $error("rv_fetch_sequencer supports XLEN = 32 only");
  end

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_inc;
  logic            redirect_aligned;
  logic            outstanding_after;

  assign pc_inc           = pc + XLEN'(INSTR_BYTES);
  assign redirect_aligned = (redirect_pc[1:0] == 2'b00);

  // A request is still owed a response after this edge if it is accepted now,
  // or was accepted earlier and its response has not arrived this cycle.
  assign outstanding_after = ((state == REQ) && imem_req_ready) ||
                             (((state == WAIT) || (state == DRAIN)) && !imem_rsp_valid);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      pc               <= RESET_PC;
      imem_req_valid   <= 1'b0;
      imem_req_addr    <= RESET_PC;
      instr_valid      <= 1'b0;
      instr_data       <= '0;
      instr_pc         <= '0;
      misaligned_fault <= 1'b0;
      fault_pc         <= '0;
    end else begin
      imem_req_valid <= 1'b0;
      instr_valid    <= 1'b0;

      if (redirect_valid && redirect_aligned) begin
        pc               <= redirect_pc;
        misaligned_fault <= 1'b0;
        if (outstanding_after) begin
          state <= DRAIN;
        end else begin
          state          <= REQ;
          imem_req_valid <= 1'b1;
          imem_req_addr  <= redirect_pc;
        end
      end else if (redirect_valid) begin
        misaligned_fault <= 1'b1;
        fault_pc         <= redirect_pc;
        state            <= outstanding_after ? DRAIN : FAULT;
      end else begin
        case (state)
          IDLE: begin
            state          <= REQ;
            imem_req_valid <= 1'b1;
            imem_req_addr  <= pc;
          end
          REQ: begin
            if (imem_req_ready) begin
              state <= WAIT;
            end else begin
              imem_req_valid <= 1'b1;
            end
          end
          WAIT: begin
            if (imem_rsp_valid) begin
              state       <= HOLD;
              instr_valid <= 1'b1;
              instr_data  <= imem_rsp_data;
              instr_pc    <= pc;
            end
          end
          HOLD: begin
            if (instr_ready) begin
              pc             <= pc_inc;
              state          <= REQ;
              imem_req_valid <= 1'b1;
              imem_req_addr  <= pc_inc;
            end else begin
              instr_valid <= 1'b1;
            end
          end
          DRAIN: begin
            // The sticky fault flag remembers whether the drain was caused by a
            // misaligned target, which decides where to go once it completes.
            if (imem_rsp_valid) begin
              if (misaligned_fault) begin
                state <= FAULT;
              end else begin
                state          <= REQ;
                imem_req_valid <= 1'b1;
                imem_req_addr  <= pc;
              end
            end
          end
          FAULT: begin
            state <= FAULT;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  rsp_only_when_expected: assert property (@(posedge clock) disable iff (!reset_n)
    imem_rsp_valid |-> ((state == WAIT) || (state == DRAIN)));

endmodule

// File: doc/rv_fetch_sequencer.md
Name: rv_fetch_sequencer

Overview:
- Front-end consumer of the jump and branch units' next-PC output. It owns the architectural PC, issues instruction-memory reads one at a time, and hands each fetched word plus its PC to decode over a valid/ready handshake.
- Accepts redirects (JAL/JALR/branch targets) at any time, squashes stale fetches, and flags misaligned targets.
- Sits between the ALU jump/branch units and the decoder in the minimal RV32I core.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- XLEN, 32, address/data width; only 32 supported.

Ports:
- clock  in  1  core clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- redirect_valid  in  1  one-cycle pulse: load redirect_pc as new PC.
- redirect_pc  in  32  jump/branch target.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  32  fetch address (word aligned).
- imem_req_ready  in  1  memory accepts request.
- imem_rsp_valid  in  1  read data valid, exactly one per accepted request.
- imem_rsp_data  in  32  instruction word.
- instr_valid  out  1  instruction available to decode.
- instr_data  out  32  instruction word.
- instr_pc  out  32  PC of instr_data.
- instr_ready  in  1  decode accepts instruction.
- misaligned_fault  out  1  sticky: last redirect target had bits [1:0] != 0.
- fault_pc  out  32  offending redirect_pc.

Behaviour:
- Reset (async assert, sync release):
  - pc = RESET_PC; state IDLE.
  - imem_req_valid = 0, instr_valid = 0, misaligned_fault = 0.
  - instr_data, instr_pc, fault_pc = 0.
- States:
  - IDLE: go to REQ one cycle after reset release.
  - REQ: imem_req_valid = 1, imem_req_addr = pc. On imem_req_ready go to WAIT.
  - WAIT: single request outstanding. On imem_rsp_valid, capture data into instr_data and pc into instr_pc, then go to HOLD.
  - HOLD: instr_valid = 1, with instr_data/instr_pc stable. On instr_ready, pc <= pc + 4 and go to REQ.
  - DRAIN: waiting for a squashed response. On imem_rsp_valid, discard it and go to REQ.
  - FAULT: no requests, instr_valid = 0. Leave only on an aligned redirect.
- Fetch throughput: at most one instruction every 3 cycles. Response latency is unbounded.
- PC arithmetic: modulo 2^32; 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Redirect, aligned (redirect_pc[1:0] == 0): pc <= redirect_pc and misaligned_fault clears. Next state depends on the current state:
  - IDLE: go to REQ at the new pc.
  - REQ without handshake that cycle: stay in REQ; the address changes next cycle. The imem interface permits address change before acceptance.
  - REQ with handshake the same cycle: go to DRAIN.
  - WAIT without response: go to DRAIN.
  - WAIT with response the same cycle: discard the response and go to REQ.
  - HOLD: instr_valid drops next cycle. If instr_ready was also high, that instruction counts as consumed. Go to REQ at redirect_pc, not pc + 4.
  - DRAIN: update pc and stay in DRAIN.
  - FAULT: go to REQ.
- Redirect, misaligned:
  - misaligned_fault <= 1 and fault_pc <= redirect_pc; pc is unchanged.
  - Outstanding request: go to DRAIN, then FAULT.
  - Otherwise (including HOLD, instruction squashed): go to FAULT.
- Redirect takes priority over normal sequencing in every state.
- imem_rsp_valid outside WAIT/DRAIN is a protocol error: ignored; a simulation assertion fires.
- Reset mid-operation: immediate return to reset values. Any in-flight memory response after release is ignored, because the first state is IDLE and then REQ.

Decomposition:
- Shared package rv_fetch_pkg holds:
  - state enum (IDLE, REQ, WAIT, HOLD, DRAIN, FAULT);
  - INSTR_BYTES = 4;
  - default RESET_PC constant, also used by the core top.
- No sub-module: the PC register, incrementer and FSM sit in one module.

Test Plan:
- Reset with RESET_PC = 32'h0000_0100, ready always 1, response 1 cycle after accept, instr_ready = 1 → fetch addresses 0x100, 0x104, 0x108, with instr_pc matching each returned word.
- instr_ready held 0 for 5 cycles in HOLD → instr_valid, instr_data and instr_pc stable; no new imem request until the cycle after instr_ready = 1.
- Redirect to 0x0000_2000 while in WAIT, response arrives 3 cycles later → response dropped (instr_valid stays 0); next request address 0x2000.
- Redirect to 0x0000_0040 in HOLD with instr_ready = 1 the same cycle → current instruction consumed once; next fetch address 0x40, not pc + 4.
- Redirect to 0x0000_0042 → misaligned_fault = 1, fault_pc = 0x42, no further requests. Then redirect to 0x80 → fault clears and the fetch of 0x80 issues.
- PC at 0xFFFF_FFFC, instruction consumed → next request address 0x0000_0000.
